// File: rtl/adc_raw_accum_if.sv
// -----------------------------------------------------------------------------
// adc_raw_accum_if
// Purpose : Carries the two AXI-Stream window-sum channels (current and
//           voltage) from the raw ADC accumulator to the fixed-to-float IP.
// Signals : c_sum_axis_tdata/tvalid/tready  current-channel sum stream
//           v_sum_axis_tdata/tvalid/tready  voltage-channel sum stream
// Modports: master - stream source (accumulator)
//           slave  - stream sink (float IP)
// -----------------------------------------------------------------------------
interface adc_raw_accum_if #(
   parameter int OUT_WIDTH = 32
);
   logic [OUT_WIDTH-1:0] c_sum_axis_tdata;
   logic                 c_sum_axis_tvalid;
   logic                 c_sum_axis_tready;
   logic [OUT_WIDTH-1:0] v_sum_axis_tdata;
   logic                 v_sum_axis_tvalid;
   logic                 v_sum_axis_tready;

   modport master (
      output c_sum_axis_tdata, c_sum_axis_tvalid,
      output v_sum_axis_tdata, v_sum_axis_tvalid,
      input  c_sum_axis_tready, v_sum_axis_tready
   );

   modport slave (
      input  c_sum_axis_tdata, c_sum_axis_tvalid,
      input  v_sum_axis_tdata, v_sum_axis_tvalid,
      output c_sum_axis_tready, v_sum_axis_tready
   );
endinterface

// File: rtl/adc_raw_accum.sv
// -----------------------------------------------------------------------------
// adc_raw_accum
// Purpose : Sums AVG_CNT consecutive raw (offset-binary) ADC samples per
//           channel and presents each window sum, zero-extended to OUT_WIDTH,
//           as an AXI-Stream word to the downstream fixed-to-float stage.
// Ports   : i_clk          system clock
//           i_rst          synchronous reset, active-high
//           i_en           accumulate enable (low = idle, window cleared)
//           i_adc_valid    sample strobe, both channels valid
//           i_c_adc_data   current-channel raw sample
//           i_v_adc_data   voltage-channel raw sample
//           sum_axis       window-sum streams (master side)
//           o_sample_cnt   samples taken in the current window
//           o_ovf          sticky flag: a window sum pair was dropped
//           i_ovf_clr      clears o_ovf (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module adc_raw_accum #(
   parameter int ADC_WIDTH = 24,
   parameter int AVG_LOG2  = 4,
   parameter int AVG_CNT   = 2**AVG_LOG2,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic                 i_adc_valid,
   input  logic [ADC_WIDTH-1:0] i_c_adc_data,
   input  logic [ADC_WIDTH-1:0] i_v_adc_data,
   adc_raw_accum_if.master      sum_axis,
   output logic [AVG_LOG2-1:0]  o_sample_cnt,
   output logic                 o_ovf,
   input  logic                 i_ovf_clr
);
   localparam int SUM_W = ADC_WIDTH + AVG_LOG2;

   typedef enum logic {ST_IDLE, ST_ACC} state_t;

   state_t              state_q, state_d;
   logic [AVG_LOG2-1:0] cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic                active_w;     // accumulating and still enabled this cycle
   logic                take_w;       // sample accepted into the window
   logic                last_w;       // accepted sample closes the window
   logic                load_w;       // both output slots free: publish sums
   logic                drop_w;       // a slot is busy: discard both sums

   // Channel 0 = current, channel 1 = voltage
   logic [ADC_WIDTH-1:0] data_w      [2];
   logic                 tready_w    [2];
   logic                 slot_free_w [2];
   logic                 tvalid_w    [2];
   logic [OUT_WIDTH-1:0] tdata_w     [2];

   assign data_w[0]   = i_c_adc_data;
   assign data_w[1]   = i_v_adc_data;
   assign tready_w[0] = sum_axis.c_sum_axis_tready;
   assign tready_w[1] = sum_axis.v_sum_axis_tready;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_en)  state_d = ST_ACC;
         ST_ACC:  if (!i_en) state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   // A strobe on the cycle i_en drops is ignored, and leaving ST_ACC wipes
   // the partial window so re-enabling always starts from an empty window.
   assign active_w = (state_q == ST_ACC) && i_en;
   assign take_w   = active_w && i_adc_valid;
   assign last_w   = take_w && (cnt_q == AVG_LOG2'(AVG_CNT - 1));
   // Channels are published as a pair so the float stage never sees them skew
   assign load_w   = last_w && slot_free_w[0] && slot_free_w[1];
   assign drop_w   = last_w && !(slot_free_w[0] && slot_free_w[1]);

   always_comb begin
      cnt_d = cnt_q;
      if (!active_w)   cnt_d = '0;
      else if (take_w) cnt_d = cnt_q + AVG_LOG2'(1);   // wraps to 0 at window end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop_w)         ovf_d = 1'b1;
      else if (i_ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // ---------------- per-channel datapath ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [SUM_W-1:0]     acc_q, acc_d;
      logic [SUM_W-1:0]     sum_w;
      logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
      logic                 tvalid_q, tvalid_d;

      // SUM_W bits hold AVG_CNT full-scale samples, so this never wraps
      assign sum_w = acc_q + SUM_W'(data_w[gi]);
      // Slot counts as free if the word in it is being accepted this cycle
      assign slot_free_w[gi] = !tvalid_q || tready_w[gi];

      always_comb begin
         acc_d = acc_q;
         if (!active_w || last_w) acc_d = '0;
         else if (take_w)         acc_d = sum_w;
      end

      always_comb begin
         tdata_d  = tdata_q;
         tvalid_d = tvalid_q;
         if (load_w) begin
            tdata_d  = OUT_WIDTH'(sum_w);
            tvalid_d = 1'b1;
         end else if (tvalid_q && tready_w[gi]) begin
            tvalid_d = 1'b0;
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
         end else begin
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
         end
      end

      assign tdata_w[gi]  = tdata_q;
      assign tvalid_w[gi] = tvalid_q;
   end

   assign sum_axis.c_sum_axis_tdata  = tdata_w[0];
   assign sum_axis.c_sum_axis_tvalid = tvalid_w[0];
   assign sum_axis.v_sum_axis_tdata  = tdata_w[1];
   assign sum_axis.v_sum_axis_tvalid = tvalid_w[1];
   assign o_sample_cnt               = cnt_q;
   assign o_ovf                      = ovf_q;
endmodule

// File: tb/tb_adc_raw_accum.sv
// -----------------------------------------------------------------------------
// tb_adc_raw_accum
// Purpose : Self-checking bench for adc_raw_accum. Directed scenarios plus a
//           randomized run, all compared every cycle against a window/queue
//           reference model of the accumulator.
// -----------------------------------------------------------------------------
module tb_adc_raw_accum;
   localparam int ADC_WIDTH = 24;
   localparam int AVG_LOG2  = 4;
   localparam int AVG_CNT   = 16;
   localparam int OUT_WIDTH = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 adc_valid;
   logic [ADC_WIDTH-1:0] c_data;
   logic [ADC_WIDTH-1:0] v_data;
   logic [AVG_LOG2-1:0]  sample_cnt;
   logic                 ovf;
   logic                 ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adc_raw_accum_if #(.OUT_WIDTH(OUT_WIDTH)) axis_if ();

   adc_raw_accum #(
      .ADC_WIDTH (ADC_WIDTH),
      .AVG_LOG2  (AVG_LOG2),
      .AVG_CNT   (AVG_CNT),
      .OUT_WIDTH (OUT_WIDTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_adc_valid  (adc_valid),
      .i_c_adc_data (c_data),
      .i_v_adc_data (v_data),
      .sum_axis     (axis_if),
      .o_sample_cnt (sample_cnt),
      .o_ovf        (ovf),
      .i_ovf_clr    (ovf_clr)
   );

   // ---------------- reference model ----------------
   // The window is the list of samples taken so far; its sum is plain arithmetic.
   logic [ADC_WIDTH-1:0] m_cq[$];
   logic [ADC_WIDTH-1:0] m_vq[$];
   bit                   m_en_prev;     // enable as seen on the previous edge
   bit                   m_c_tvalid, m_v_tvalid, m_ovf;
   logic [31:0]          m_c_tdata, m_v_tdata;

   function automatic logic [31:0] win_sum(input logic [ADC_WIDTH-1:0] q[$]);
      logic [31:0] s = 0;
      foreach (q[i]) s += 32'(q[i]);
      return s;
   endfunction

   task automatic model_step();
      bit c_free, v_free, dropped;
      if (rst) begin
         m_cq.delete();
         m_vq.delete();
         m_en_prev  = 0;
         m_c_tvalid = 0;
         m_v_tvalid = 0;
         m_c_tdata  = 0;
         m_v_tdata  = 0;
         m_ovf      = 0;
         return;
      end
      dropped = 0;
      c_free  = !m_c_tvalid || axis_if.c_sum_axis_tready;
      v_free  = !m_v_tvalid || axis_if.v_sum_axis_tready;
      if (m_c_tvalid && axis_if.c_sum_axis_tready) m_c_tvalid = 0;
      if (m_v_tvalid && axis_if.v_sum_axis_tready) m_v_tvalid = 0;
      if (!(m_en_prev && en)) begin
         m_cq.delete();
         m_vq.delete();
      end else if (adc_valid) begin
         m_cq.push_back(c_data);
         m_vq.push_back(v_data);
         if (m_cq.size() == AVG_CNT) begin
            if (c_free && v_free) begin
               m_c_tdata  = win_sum(m_cq);
               m_v_tdata  = win_sum(m_vq);
               m_c_tvalid = 1;
               m_v_tvalid = 1;
            end else begin
               dropped = 1;
            end
            m_cq.delete();
            m_vq.delete();
         end
      end
      if (dropped)      m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_en_prev = en;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("c_tvalid",   32'(axis_if.c_sum_axis_tvalid), 32'(m_c_tvalid));
      check("v_tvalid",   32'(axis_if.v_sum_axis_tvalid), 32'(m_v_tvalid));
      check("c_tdata",    axis_if.c_sum_axis_tdata, m_c_tdata);
      check("v_tdata",    axis_if.v_sum_axis_tdata, m_v_tdata);
      check("sample_cnt", 32'(sample_cnt), 32'(m_cq.size()));
      check("ovf",        32'(ovf), 32'(m_ovf));
   endtask

   task automatic strobe(input logic [ADC_WIDTH-1:0] c, input logic [ADC_WIDTH-1:0] v);
      adc_valid = 1'b1;
      c_data    = c;
      v_data    = v;
      step();
      adc_valid = 1'b0;
   endtask

   task automatic set_ready(input bit r);
      axis_if.c_sum_axis_tready = r;
      axis_if.v_sum_axis_tready = r;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      adc_valid = 1'b0;
      c_data    = '0;
      v_data    = '0;
      ovf_clr   = 1'b0;
      set_ready(1'b1);

      step();
      step();
      check("rst_c_tvalid", 32'(axis_if.c_sum_axis_tvalid), 32'd0);
      check("rst_cnt",      32'(sample_cnt), 32'd0);
      rst = 1'b0;
      $display("[TB] reset done");

      // 1: mid-scale on both channels
      en = 1'b1;
      step();
      for (int i = 0; i < AVG_CNT; i++) strobe(24'h800000, 24'h800000);
      check("t1_c_word", axis_if.c_sum_axis_tdata, 32'h08000000);
      check("t1_v_word", axis_if.v_sum_axis_tdata, 32'h08000000);
      check("t1_c_valid", 32'(axis_if.c_sum_axis_tvalid), 32'd1);
      step();
      check("t1_valid_drop", 32'(axis_if.c_sum_axis_tvalid), 32'd0);
      $display("[TB] test1 mid-scale window: c=0x%08h", axis_if.c_sum_axis_tdata);

      // 2: full scale on current, zero on voltage
      for (int i = 0; i < AVG_CNT; i++) strobe(24'hFFFFFF, 24'h000000);
      check("t2_c_word", axis_if.c_sum_axis_tdata, 32'h0FFFFFF0);
      check("t2_v_word", axis_if.v_sum_axis_tdata, 32'h00000000);
      check("t2_ovf", 32'(ovf), 32'd0);
      $display("[TB] test2 full-scale window: c=0x%08h v=0x%08h",
               axis_if.c_sum_axis_tdata, axis_if.v_sum_axis_tdata);

      // 3: backpressure over two windows drops the second pair
      set_ready(1'b0);
      for (int i = 0; i < 2 * AVG_CNT; i++) strobe(24'($urandom), 24'($urandom));
      check("t3_ovf_set", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(ovf), 32'd0);
      set_ready(1'b1);
      step();
      $display("[TB] test3 backpressure overflow/clear");

      // 4: window end coincides with acceptance of the previous word
      set_ready(1'b0);
      for (int i = 0; i < AVG_CNT; i++) strobe(24'($urandom), 24'($urandom));
      for (int i = 0; i < AVG_CNT - 1; i++) strobe(24'd5, 24'd7);
      set_ready(1'b1);
      strobe(24'd5, 24'd7);
      check("t4_c_word", axis_if.c_sum_axis_tdata, 32'd80);
      check("t4_v_word", axis_if.v_sum_axis_tdata, 32'd112);
      check("t4_ovf", 32'(ovf), 32'd0);
      step();
      $display("[TB] test4 handoff on window end");

      // 5: disable mid-window discards the partial window
      for (int i = 0; i < 7; i++) strobe(24'h100000, 24'h100000);
      en = 1'b0;
      step();
      check("t5_idle_cnt", 32'(sample_cnt), 32'd0);
      step();
      en = 1'b1;
      step();
      for (int i = 0; i < AVG_CNT; i++) strobe(24'd1, 24'd2);
      check("t5_c_word", axis_if.c_sum_axis_tdata, 32'd16);
      check("t5_v_word", axis_if.v_sum_axis_tdata, 32'd32);
      step();
      $display("[TB] test5 enable drop mid-window");

      // 6: reset with a pending word and a partial window
      set_ready(1'b0);
      for (int i = 0; i < AVG_CNT; i++) strobe(24'($urandom), 24'($urandom));
      for (int i = 0; i < 10; i++) strobe(24'($urandom), 24'($urandom));
      rst = 1'b1;
      step();
      check("t6_c_valid", 32'(axis_if.c_sum_axis_tvalid), 32'd0);
      check("t6_c_data",  axis_if.c_sum_axis_tdata, 32'd0);
      check("t6_cnt",     32'(sample_cnt), 32'd0);
      rst = 1'b0;
      set_ready(1'b1);
      step();
      for (int i = 0; i < AVG_CNT; i++) strobe(24'd3, 24'd4);
      check("t6_c_word", axis_if.c_sum_axis_tdata, 32'd48);
      check("t6_v_word", axis_if.v_sum_axis_tdata, 32'd64);
      $display("[TB] test6 reset mid-window");

      // Randomized run: sparse strobes, jittery ready, occasional disable/clear/reset
      for (int i = 0; i < 4000; i++) begin
         rst                       = ($urandom_range(0, 999) == 0);
         en                        = ($urandom_range(0, 49) != 0);
         adc_valid                 = ($urandom_range(0, 2) != 0);
         c_data                    = 24'($urandom);
         v_data                    = 24'($urandom);
         axis_if.c_sum_axis_tready = ($urandom_range(0, 3) != 0);
         axis_if.v_sum_axis_tready = ($urandom_range(0, 3) != 0);
         ovf_clr                   = ($urandom_range(0, 63) == 0);
         step();
      end
      $display("[TB] random run done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
